// File: rtl/serial_logic_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_logic_unit_pkg
// Description : Shared opcode, state and sizing definitions for the
//               bit-serial logic unit.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_logic_unit_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DIGIT = 1;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_logic_unit_logic_slice.sv
`default_nettype none
// ============================================================================
// Module      : logic_slice
// Description : Combinational DIGIT-wide bitwise gate for one serial step.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_slice
    import serial_logic_unit_pkg::*;
#(
    parameter int DIGIT = DEFAULT_DIGIT
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic [1:0]       op,
    output logic [DIGIT-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOR:  y = ~(a | b);
            default: y = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/serial_logic_unit.sv
`default_nettype none
// ============================================================================
// Module      : serial_logic_unit
// Description : Bit-serial WIDTH-bit AND/OR/XOR/NOR unit, DIGIT bits per clock,
//               LSB first, start/ready handshake and one-cycle done pulse.
//               Optional zero flag output: SERIAL_LOGIC_ZERO_FLAG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_logic_unit
    import serial_logic_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DIGIT = DEFAULT_DIGIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int              c_N    = WIDTH / DIGIT;
    localparam int              c_CW   = (c_N > 1) ? $clog2(c_N) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_N - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_op;
    logic [c_CW-1:0]  r_cnt;
    logic [DIGIT-1:0] w_y;
    logic [WIDTH-1:0] w_result_next;
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
    logic             r_any;
`endif

    logic_slice #(
        .DIGIT (DIGIT)
    ) u_slice (
        .a  (r_a[DIGIT-1:0]),
        .b  (r_b[DIGIT-1:0]),
        .op (r_op),
        .y  (w_y)
    );

    // New slice enters at the MSB end so the word is LSB-aligned after N steps.
    generate
        if (WIDTH > DIGIT) begin : g_shift_wide
            assign w_result_next = {w_y, result[WIDTH-1:DIGIT]};
        end else begin : g_shift_single
            assign w_result_next = w_y;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            ready   <= 1'b1;
            done    <= 1'b0;
            result  <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_cnt   <= '0;
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
            r_any   <= 1'b0;
            zero    <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a     <= in1;
                        r_b     <= in2;
                        r_op    <= op;
                        r_cnt   <= '0;
                        ready   <= 1'b0;
                        r_state <= RUN;
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
                        r_any   <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    r_a    <= r_a >> DIGIT;
                    r_b    <= r_b >> DIGIT;
                    result <= w_result_next;
                    r_cnt  <= r_cnt + 1'b1;
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
                    r_any  <= r_any | (|w_y);
`endif
                    if (r_cnt == c_LAST) begin
                        done    <= 1'b1;
                        r_state <= DONE;
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
                        zero    <= ~(r_any | (|w_y));
`endif
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    ready   <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    ready   <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
